// File: rtl/mult_share_arbiter_if.sv
// Bus bundle between two multiply clients, the shared multiplier and the
// arbiter that multiplexes them.
//   slave  : arbiter view (requests, operands, multiplier product in; grants,
//            dones, product, busy and multiplier load/operands out)
//   master : environment view (clients plus the external multiplier)
interface mult_share_arbiter_if #(
  parameter int unsigned WIDTH = 6
);
  localparam int unsigned PROD_W = 2 * WIDTH;

  // Requester 0
  logic              req0;
  logic [WIDTH-1:0]  a0;
  logic [WIDTH-1:0]  b0;
  logic              gnt0;
  logic              done0;

  // Requester 1
  logic              req1;
  logic [WIDTH-1:0]  a1;
  logic [WIDTH-1:0]  b1;
  logic              gnt1;
  logic              done1;

  // Shared result and status
  logic [PROD_W-1:0] product;
  logic              busy;

  // Multiplier side
  logic              mult_load;
  logic [WIDTH-1:0]  mult_a;
  logic [WIDTH-1:0]  mult_b;
  logic [PROD_W-1:0] mult_product;

  modport slave (
    input  req0, a0, b0, req1, a1, b1, mult_product,
    output gnt0, gnt1, done0, done1, product, busy, mult_load, mult_a, mult_b
  );

  modport master (
    output req0, a0, b0, req1, a1, b1, mult_product,
    input  gnt0, gnt1, done0, done1, product, busy, mult_load, mult_a, mult_b
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin controller sharing one external sequential multiplier between
// two requesters. Captures the winner's operands, strobes the multiplier
// load, waits out the fixed multiplier latency, then returns the product
// with a one-cycle done pulse to the owning requester.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - slave side of mult_share_arbiter_if (requests/operands in,
//          grant/done pulses, product, busy, multiplier load/operands out)
module mult_share_arbiter #(
  parameter int unsigned WIDTH    = 6,
  parameter int unsigned MULT_LAT = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  mult_share_arbiter_if.slave   bus
);

  localparam int unsigned PROD_W = 2 * WIDTH;
  localparam int unsigned CNT_W  = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               owner_q, owner_d;
  logic               last_q, last_d;
  logic               gnt0_q, gnt0_d;
  logic               gnt1_q, gnt1_d;
  logic               done0_q, done0_d;
  logic               done1_q, done1_d;
  logic [PROD_W-1:0]  product_q, product_d;
  logic               busy_q, busy_d;
  logic               mult_load_q, mult_load_d;
  logic [WIDTH-1:0]   mult_a_q, mult_a_d;
  logic [WIDTH-1:0]   mult_b_q, mult_b_d;
  logic               win1;

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      product_q   <= '0;
      busy_q      <= 1'b0;
      mult_load_q <= 1'b0;
      mult_a_q    <= '0;
      mult_b_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      product_q   <= product_d;
      busy_q      <= busy_d;
      mult_load_q <= mult_load_d;
      mult_a_q    <= mult_a_d;
      mult_b_q    <= mult_b_d;
    end
  end

  // Requester 1 wins if alone, or on a tie when requester 0 was served last
  assign win1 = bus.req1 && (!bus.req0 || !last_q);

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    last_d      = last_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    done0_d     = 1'b0;
    done1_d     = 1'b0;
    product_d   = product_q;
    mult_load_d = 1'b0;
    mult_a_d    = mult_a_q;
    mult_b_d    = mult_b_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          owner_d     = win1;
          mult_a_d    = win1 ? bus.a1 : bus.a0;
          mult_b_d    = win1 ? bus.b1 : bus.b0;
          gnt0_d      = !win1;
          gnt1_d      = win1;
          mult_load_d = 1'b1;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(MULT_LAT - 1)) begin
          product_d = bus.mult_product;
          done0_d   = !owner_q;
          done1_d   = owner_q;
          last_d    = owner_q;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Busy mirrors the registered state so it stays aligned with it
    busy_d = (state_d != IDLE);
  end

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.done0     = done0_q;
  assign bus.done1     = done1_q;
  assign bus.product   = product_q;
  assign bus.busy      = busy_q;
  assign bus.mult_load = mult_load_q;
  assign bus.mult_a    = mult_a_q;
  assign bus.mult_b    = mult_b_q;

endmodule
